// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and ratio-code constants for the divider sweep
package divider_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, DWELL = 2'd2} state_t;
  localparam logic [3:0] DIV_CODE_MAX = 4'd9;
  localparam logic [3:0] DIV_CODE_RESET = 4'd1;
  localparam logic [3:0] DIV_CODE_20 = 4'd0;
endpackage

// File: rtl/opt_edge_counter.sv
// opt_edge_counter: counts rising edges of the divider output and flags the target count
module opt_edge_counter
  import divider_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         opt_in,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         hit
);
  logic         opt_d;
  logic [W-1:0] cnt;
  logic         rise;
  logic [W:0]   cnt_nxt;
  assign rise = opt_in & ~opt_d;
  assign cnt_nxt = {1'b0, cnt} + {{W{1'b0}}, 1'b1};
  assign hit = en & rise & (cnt_nxt == {1'b0, target});
  // opt_d tracks opt_in in every state; the count only advances while enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      opt_d <= 1'b0;
      cnt <= '0;
    end else begin
      opt_d <= opt_in;
      if (clr) cnt <= '0;
      else if (en & rise) cnt <= cnt_nxt[W-1:0];
    end
  end
endmodule

// File: rtl/divider_sweep_ctrl.sv
// divider_sweep_ctrl: steps the divider ratio code through a range with settle and dwell per code
module divider_sweep_ctrl
  import divider_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         n_lo,
  input  logic [3:0]         n_hi,
  input  logic               dir,
  input  logic               loop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               opt_in,
  output logic [3:0]         n,
  output logic               busy,
  output logic               step_done,
  output logic               sweep_done,
  output logic               cfg_err
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  state_t             state;
  logic [SW-1:0]      scnt;
  logic [3:0]         lo_q, hi_q;
  logic               dir_q, loop_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               hit;
  logic [3:0]         first, nxt;
  logic               last, bad;
  assign first = dir_q ? hi_q : lo_q;
  assign nxt = dir_q ? n - 4'd1 : n + 4'd1;
  assign last = n == (dir_q ? lo_q : hi_q);
  assign bad = (n_lo > DIV_CODE_MAX) || (n_hi > DIV_CODE_MAX) || (n_lo > n_hi);
  opt_edge_counter #(.W(DWELL_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .opt_in (opt_in),
    .clr    (state != DWELL),
    .en     (state == DWELL),
    .target (dwell_q == '0 ? DWELL_W'(1) : dwell_q),
    .hit    (hit)
  );
  // sweep FSM; stop overrides everything else and suppresses the done strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scnt <= '0;
      n <= DIV_CODE_RESET;
      busy <= 1'b0;
      step_done <= 1'b0;
      sweep_done <= 1'b0;
      cfg_err <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      dir_q <= 1'b0;
      loop_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      step_done <= 1'b0;
      sweep_done <= 1'b0;
      cfg_err <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (bad) cfg_err <= 1'b1;
            else begin
              lo_q <= n_lo;
              hi_q <= n_hi;
              dir_q <= dir;
              loop_q <= loop;
              dwell_q <= dwell;
              n <= dir ? n_hi : n_lo;
              scnt <= '0;
              busy <= 1'b1;
              state <= SETTLE;
            end
          end
          SETTLE: begin
            scnt <= scnt + 1'b1;
            if (scnt == SW'(SETTLE_CYC - 1)) begin
              scnt <= '0;
              state <= DWELL;
            end
          end
          DWELL: if (hit) begin
            step_done <= 1'b1;
            if (!last) begin
              n <= nxt;
              state <= SETTLE;
            end else begin
              sweep_done <= 1'b1;
              if (loop_q) begin
                n <= first;
                state <= SETTLE;
              end else begin
                busy <= 1'b0;
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_divider_sweep_ctrl.sv
// tb_divider_sweep_ctrl: directed checks of the divider sweep sequencer
module tb_divider_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, stop, dir, loop;
  logic [3:0] n_lo, n_hi;
  logic [7:0] dwell;
  logic       opt_in, opt_man, div_opt, use_div;
  logic [3:0] n;
  logic       busy, step_done, sweep_done, cfg_err;
  int         checks = 0;
  int         errors = 0;
  int         dcnt, period;
  int         steps, sweeps, sweep_mask, busy_at_sweep, k;
  logic [3:0] seen [8];

  always #5 clk = ~clk;

  divider_sweep_ctrl #(.DWELL_W(8), .SETTLE_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .n_lo       (n_lo),
    .n_hi       (n_hi),
    .dir        (dir),
    .loop       (loop),
    .dwell      (dwell),
    .opt_in     (opt_in),
    .n          (n),
    .busy       (busy),
    .step_done  (step_done),
    .sweep_done (sweep_done),
    .cfg_err    (cfg_err)
  );

  assign period = (n == 4'd0) ? 20 : (1 << n);
  assign opt_in = use_div ? div_opt : opt_man;

  // behavioural n_divider: registered square wave of the selected period
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= 0;
      div_opt <= 1'b0;
    end else begin
      dcnt <= (dcnt + 1 >= period) ? 0 : dcnt + 1;
      div_opt <= dcnt < period / 2;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] lo, input logic [3:0] hi, input logic d, input logic l, input logic [7:0] dw);
    n_lo = lo;
    n_hi = hi;
    dir = d;
    loop = l;
    dwell = dw;
  endtask

  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic run_steps(input int want_steps, input int want_sweeps, input int budget);
    steps = 0;
    sweeps = 0;
    sweep_mask = 0;
    busy_at_sweep = 1;
    for (int c = 0; c < budget && steps < want_steps && sweeps < want_sweeps; c++) begin
      tick;
      if (step_done) begin
        if (steps < 8) seen[steps] = n;
        steps++;
      end
      if (sweep_done) begin
        sweeps++;
        sweep_mask |= 1 << (steps - 1);
        busy_at_sweep = busy;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; opt_man = 1'b0; use_div = 1'b0;
    cfg(4'd0, 4'd0, 1'b0, 1'b0, 8'd0);
    tick;
    tick;
    chk("rst_n", n, 4'd1);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {step_done, sweep_done, cfg_err}, 0);
    rst = 1'b0;
    tick;

    cfg(4'd5, 4'd2, 1'b0, 1'b0, 8'd1);
    go;
    chk("err_lohi_cfg", cfg_err, 1);
    chk("err_lohi_busy", busy, 0);
    chk("err_lohi_n", n, 4'd1);
    tick;
    chk("err_pulse_end", cfg_err, 0);
    cfg(4'd5, 4'd12, 1'b0, 1'b0, 8'd1);
    go;
    chk("err_hi12_cfg", cfg_err, 1);
    chk("err_hi12_state", {busy, n}, {1'b0, 4'd1});
    tick;

    cfg(4'd2, 4'd2, 1'b0, 1'b0, 8'd1);
    go;
    chk("t0_n", n, 4'd2);
    chk("t0_busy", busy, 1);
    tick;
    cfg(4'd7, 4'd7, 1'b1, 1'b1, 8'd5);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    opt_man = 1'b1;
    tick;
    chk("settle_edge_ignored", step_done, 0);
    chk("busy_start_ignored_n", n, 4'd2);
    opt_man = 1'b0;
    tick;
    chk("no_step_yet", step_done, 0);
    opt_man = 1'b1;
    tick;
    chk("single_step", step_done, 1);
    chk("single_sweep", sweep_done, 1);
    chk("single_busy", busy, 0);
    chk("single_n", n, 4'd2);
    opt_man = 1'b0;
    tick;
    chk("single_idle", {step_done, sweep_done, busy}, 0);

    use_div = 1'b1;
    cfg(4'd1, 4'd3, 1'b0, 1'b0, 8'd2);
    go;
    chk("asc_first_n", n, 4'd1);
    run_steps(8, 1, 600);
    for (int c = 0; c < 30; c++) begin
      tick;
      if (step_done) steps++;
    end
    chk("asc_steps", steps, 3);
    chk("asc_sweeps", sweeps, 1);
    chk("asc_sweep_on_step3", sweep_mask, 32'b100);
    chk("asc_seq", {seen[0], seen[1], seen[2]}, {4'd2, 4'd3, 4'd3});
    chk("asc_busy_falls", busy_at_sweep, 0);
    chk("asc_final_n", n, 4'd3);

    cfg(4'd1, 4'd3, 1'b1, 1'b1, 8'd1);
    go;
    chk("desc_first_n", n, 4'd3);
    run_steps(6, 8, 1000);
    chk("loop_steps", steps, 6);
    chk("loop_seq", {seen[0], seen[1], seen[2], seen[3], seen[4], seen[5]},
        {4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3});
    chk("loop_sweeps", sweep_mask, 32'b100100);
    chk("loop_busy", busy_at_sweep, 1);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_n", n, 4'd3);
    k = 0;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (step_done || sweep_done || busy) k++;
    end
    chk("stop_quiet", k, 0);

    cfg(4'd0, 4'd0, 1'b0, 1'b0, 8'd0);
    go;
    chk("zero_n", n, 4'd0);
    k = 0;
    steps = 0;
    for (int c = 1; c <= 40 && steps == 0; c++) begin
      tick;
      if (step_done) begin
        steps = 1;
        k = c;
        chk("zero_sweep_together", sweep_done, 1);
      end
    end
    chk("zero_step_seen", steps, 1);
    chk("zero_latency", (k >= 5 && k <= 25) ? 1 : 0, 1);

    use_div = 1'b0;
    opt_man = 1'b0;
    cfg(4'd4, 4'd4, 1'b0, 1'b0, 8'd1);
    go;
    repeat (4) tick;
    opt_man = 1'b1;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_edge_step", {step_done, sweep_done}, 0);
    chk("stop_edge_busy", busy, 0);
    chk("stop_edge_n", n, 4'd4);
    opt_man = 1'b0;
    tick;

    cfg(4'd6, 4'd6, 1'b0, 1'b0, 8'd3);
    go;
    repeat (4) tick;
    for (int e = 0; e < 2; e++) begin
      opt_man = 1'b1;
      tick;
      opt_man = 1'b0;
      tick;
    end
    chk("dwell3_pending", {step_done, busy, n}, {1'b0, 1'b1, 4'd6});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_dwell_n", n, 4'd1);
    chk("rst_dwell_outs", {busy, step_done, sweep_done, cfg_err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider_sweep_ctrl.md
# divider_sweep_ctrl

Sequencer for the power-of-two/20 clock divider. Drives the divider's 4-bit ratio code `n` through a programmed range, ascending or descending, once or looped. At each setting it waits a settle window, then dwells for a programmed number of divider output periods. The block sits between the top-level control/UI logic and `n_divider`, and produces step and sweep completion strobes for downstream measurement and display logic.

## Interface
Parameters:
- `DWELL_W`, 8: width of the dwell count.
- `SETTLE_CYC`, 4: clk cycles spent in SETTLE after each `n` change (≥1).

Ports:
- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled request; accepted only in IDLE.
- `stop` in 1: abort; effective in any state.
- `n_lo` in 4: low end of sweep range (code 0 = ÷20, codes 1–9 = ÷2^code).
- `n_hi` in 4: high end of sweep range.
- `dir` in 1: 0 = ascending (`n_lo`→`n_hi`); 1 = descending (`n_hi`→`n_lo`).
- `loop` in 1: 1 = restart from the first code after the last step.
- `dwell` in DWELL_W: divider output rising edges per step; 0 is treated as 1.
- `opt_in` in 1: the divider's registered output, same clk domain.
- `n` out 4: ratio code to the divider.
- `busy` out 1: high in SETTLE and DWELL.
- `step_done` out 1: one-cycle pulse at the end of each step.
- `sweep_done` out 1: one-cycle pulse at the end of each pass.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, SETTLE, DWELL.
- Reset values: state IDLE, `n`=4'd1 (÷2), `busy`/`step_done`/`sweep_done`/`cfg_err`=0, all counters 0.
- Config check in IDLE on `start`:
  - Reject when `n_lo`>9, `n_hi`>9, or `n_lo`>`n_hi`.
  - On reject, `cfg_err` pulses, state remains IDLE, and `n` is unchanged.
- Valid `start`:
  - `n_lo`, `n_hi`, `dir`, `loop` and `dwell` are latched.
  - `n` is set to the first code: `n_lo` if ascending, `n_hi` if descending.
  - State moves to SETTLE.
- SETTLE: counts `SETTLE_CYC` cycles, then moves to DWELL with the edge counter at 0. Edges are ignored during SETTLE.
- DWELL:
  - Rising edge = `opt_in` & ~`opt_d`, where `opt_d` is `opt_in` registered one cycle. `opt_d` is updated in every state.
  - When an edge brings the count to the effective dwell:
    - If not the last code: `n` steps ±1 and state moves to SETTLE.
    - If the last code and `loop`=1: `n` reloads the first code and state moves to SETTLE.
    - If the last code and `loop`=0: state moves to IDLE.
- Ordering of codes is numeric, so code 0 (÷20) is the first code when ascending from `n_lo`=0.
- Single-code range (`n_lo`=`n_hi`) is legal: every step is also the last step.
- `stop`:
  - Next cycle the state is IDLE, `busy`=0, `n` holds its current value, and no done pulses are issued.
  - `stop` has priority over `start` and over a dwell-completing edge in the same cycle.
- `start` while busy is ignored; it is not queued.
- `rst` asserted mid-sweep returns everything to reset values on the next edge.
- Latched config is immune to input changes during a sweep.

## Timing
- `start` sampled at edge T (valid config): at T+1, `n`=first code and `busy`=1.
- SETTLE occupies cycles T+1 … T+SETTLE_CYC. DWELL begins at T+SETTLE_CYC+1.
- Completing edge detected in cycle C: at C+1, `step_done`=1 and `n`=next code (or unchanged on the final step of a non-loop sweep).
- Final step, `loop`=0: at C+1, `step_done`=`sweep_done`=1 and `busy`=0 in the same cycle.
- Final step, `loop`=1: at C+1, `step_done`=`sweep_done`=1, `busy` stays 1, `n`=first code.
- `cfg_err` appears one cycle after the rejected `start` sample.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `divider_pkg`:
  - State enum (IDLE/SETTLE/DWELL).
  - `DIV_CODE_MAX`=4'd9.
  - `DIV_CODE_RESET`=4'd1.
  - `DIV_CODE_20`=4'd0.
- One sub-module, `opt_edge_counter`:
  - Registers `opt_in`, detects the rising edge, and counts edges.
  - Inputs: clear and enable.
  - Output: a `hit` flag when the count reaches the target.
- The top holds the FSM, settle counter, `n` register and config latches.

## Test plan
- `n_lo`=1, `n_hi`=3, `dir`=0, `loop`=0, `dwell`=2, real `n_divider` attached:
  - `n` sequence 1→2→3; three `step_done` pulses; one `sweep_done`, coincident with the third `step_done`.
  - `busy` falls with `sweep_done`; `n` stays 3.
- Same range with `dir`=1, `loop`=1, `dwell`=1:
  - `n` sequence 3,2,1,3,2,1…; `sweep_done` pulses each time `n` reloads to 3.
  - `stop` mid-SETTLE → IDLE next cycle, no pulses, `n` held.
- `n_lo`=5, `n_hi`=2 or `n_hi`=12 → `cfg_err` pulse one cycle after `start`; `busy`=0; `n` unchanged.
- `n_lo`=`n_hi`=0, `dwell`=0 → `n`=0 (÷20); `step_done` and `sweep_done` pulse together after 1 edge, i.e. ≤20 cycles after SETTLE ends.
- Dwell-completing edge and `stop` in the same cycle → no `step_done`; `rst` asserted in DWELL → `n`=1 and all outputs 0 next cycle.
- `start` pulsed while busy → ignored, sweep sequence unchanged; `SETTLE_CYC`=4 → first DWELL edge counted no earlier than T+5.
